ifm_bank_pingpong_ctrl: RTL
===========================

Name: ifm_bank_pingpong_ctrl

Overview:
- Controls the ping-pong IFM bank pair between two convolution layers: a producer CU (e.g. convb2 stage) writes banks, a consumer CU reads them.
- Tracks which banks hold finished feature maps and steers producer write / consumer read bank selects.
- Issues the start pulse to the consumer and back-pressures the producer when every bank is full.
- Replaces the single-bank start_to_next/end_from_next lock-step with NUMBER_OF_BANKS-deep decoupling.

Parameters:
NUMBER_OF_BANKS, 2, number of IFM banks between the layers (>=2)
BANK_SEL_WIDTH, ($clog2(NUMBER_OF_BANKS) < 1 ? 1 : $clog2(NUMBER_OF_BANKS)), width of bank select outputs
COUNT_WIDTH, $clog2(NUMBER_OF_BANKS+1), width of full-bank count
STALL_CNT_WIDTH, 16, width of producer stall counter

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
prod_done  input  1  1-cycle pulse: producer finished writing bank wr_bank_sel
prod_ready  output  1  level: a free bank exists, producer may start a new bank
wr_bank_sel  output  BANK_SEL_WIDTH  bank the producer writes
cons_idle  input  1  level from consumer (its end_to_previous): 1 = idle
start_to_next  output  1  1-cycle pulse: consumer starts on bank rd_bank_sel
rd_bank_sel  output  BANK_SEL_WIDTH  bank the consumer reads
full_count  output  COUNT_WIDTH  banks written and not yet released (includes bank in use)
overflow_err  output  1  sticky: prod_done received while full
stall_cycles  output  STALL_CNT_WIDTH  saturating count of cycles with prod_ready=0

Behaviour:
- Reset (reset=0, async): wr_bank_sel=0, rd_bank_sel=0, full_count=0, overflow_err=0, stall_cycles=0, start_to_next=0, FSM=C_IDLE. prod_ready is therefore 1 while in reset.
- prod_ready = (full_count != NUMBER_OF_BANKS), decoded from registers, no input path.
- Accept: prod_done & prod_ready -> next cycle full_count+1 and wr_bank_sel+1. wr_bank_sel wraps NUMBER_OF_BANKS-1 -> 0.
- Overflow: prod_done & ~prod_ready -> ignored (no count or pointer change). overflow_err set to 1 and held until reset.
- Consumer FSM, Moore outputs:
  - C_IDLE: start_to_next=0. If full_count!=0 & cons_idle -> C_START.
  - C_START: start_to_next=1 for exactly this one cycle. Always -> C_ACK.
  - C_ACK: waits for cons_idle=0 (consumer accepted), then -> C_BUSY. No timeout; waits indefinitely.
  - C_BUSY: when cons_idle=1 -> release: full_count-1, rd_bank_sel+1 (wraps to 0), -> C_IDLE.
- Latency:
  - prod_done in cycle n (controller idle, consumer idle) -> full_count=1 in n+1 -> start_to_next=1 in cycle n+2.
  - After a release, the earliest next start_to_next is 2 cycles later.
- Simultaneous accept and release in the same cycle: full_count unchanged, both selects advance.
  - When full, a release frees a bank, but prod_ready is only updated the following cycle. A prod_done arriving in the release cycle counts as overflow.
- rd_bank_sel is stable from C_START through the release cycle. wr_bank_sel never equals a bank that is full and unreleased while prod_ready=1.
- stall_cycles increments each cycle prod_ready=0 and saturates at all-ones.
- Reset mid-operation discards all bank state. The consumer must also be reset; no pending start is replayed.

Test Plan:
- Reset then a single prod_done at cycle 10 with cons_idle=1 -> full_count=1 at 11, start_to_next=1 only at cycle 12 with rd_bank_sel=0, wr_bank_sel=1.
- Consumer drops cons_idle at 14 and raises it at 40 -> release at 40, full_count=0 at 41, rd_bank_sel=1, no further start_to_next.
- Hold cons_idle=0 and pulse prod_done twice (NUMBER_OF_BANKS=2) -> full_count=2, prod_ready=0, stall_cycles counts 1,2,3..; a third prod_done sets overflow_err=1 with full_count still 2.
- With full_count=1, prod_done in the same cycle as the release -> full_count stays 1, wr_bank_sel and rd_bank_sel both advance by 1.
- Drive reset=0 asynchronously mid C_BUSY (between clock edges) -> all outputs return to reset values immediately, FSM in C_IDLE after reset is released.
- NUMBER_OF_BANKS=3 with 6 back-to-back producer banks and a slow consumer -> bank order 0,1,2,0,1,2 on both selects, no overflow, prod_ready low only while full_count=3.

Source files
------------

// File: rtl/ifm_bank_pingpong_ctrl.sv
// Ping-pong IFM bank controller between a producer CU and a consumer CU.
// Tracks full banks, steers write/read bank selects, and starts the consumer.
module ifm_bank_pingpong_ctrl #(
  parameter int NUMBER_OF_BANKS = 2,
  parameter int BANK_SEL_WIDTH  = ($clog2(NUMBER_OF_BANKS) < 1 ? 1 : $clog2(NUMBER_OF_BANKS)),
  parameter int COUNT_WIDTH     = $clog2(NUMBER_OF_BANKS + 1),
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       prod_done,
  output logic                       prod_ready,
  output logic [BANK_SEL_WIDTH-1:0]  wr_bank_sel,
  input  logic                       cons_idle,
  output logic                       start_to_next,
  output logic [BANK_SEL_WIDTH-1:0]  rd_bank_sel,
  output logic [COUNT_WIDTH-1:0]     full_count,
  output logic                       overflow_err,
  output logic [STALL_CNT_WIDTH-1:0] stall_cycles,
  output logic [1:0]                 cons_state
);

  // Handshakes: the producer owns a bank once prod_ready=1 and hands it over
  // with a one-cycle prod_done; the consumer is kicked by a one-cycle
  // start_to_next, acknowledges by dropping cons_idle and returns the bank by
  // raising cons_idle again. A prod_done while prod_ready=0 is dropped.
  typedef enum logic [1:0] {C_IDLE, C_START, C_ACK, C_BUSY} cons_state_t;

  localparam logic [BANK_SEL_WIDTH-1:0] LAST_BANK  = BANK_SEL_WIDTH'(NUMBER_OF_BANKS - 1);
  localparam logic [COUNT_WIDTH-1:0]    BANKS_FULL = COUNT_WIDTH'(NUMBER_OF_BANKS);

  cons_state_t state, state_next;
  logic        accept;
  logic        bank_release;

  assign prod_ready = (full_count != BANKS_FULL);
  assign accept     = prod_done & prod_ready;
  assign cons_state = state;

  always_comb begin
    state_next    = state;
    start_to_next = 1'b0;
    bank_release  = 1'b0;
    case (state)
      C_IDLE: begin
        if ((full_count != '0) && cons_idle) state_next = C_START;
      end
      C_START: begin
        start_to_next = 1'b1;
        state_next    = C_ACK;
      end
      C_ACK: begin
        if (!cons_idle) state_next = C_BUSY;
      end
      C_BUSY: begin
        if (cons_idle) begin
          bank_release = 1'b1;
          state_next   = C_IDLE;
        end
      end
      default: state_next = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= C_IDLE;
    else        state <= state_next;
  end

  // Simultaneous accept and release cancel in the count; both pointers move.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_count <= '0;
    end else begin
      case ({accept, bank_release})
        2'b10:   full_count <= full_count + 1'b1;
        2'b01:   full_count <= full_count - 1'b1;
        default: full_count <= full_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bank_sel <= '0;
      rd_bank_sel <= '0;
    end else begin
      if (accept)       wr_bank_sel <= (wr_bank_sel == LAST_BANK) ? '0 : wr_bank_sel + 1'b1;
      if (bank_release) rd_bank_sel <= (rd_bank_sel == LAST_BANK) ? '0 : rd_bank_sel + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_err <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (prod_done && !prod_ready) overflow_err <= 1'b1;
      if (!prod_ready && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule
